endstop_guard: RTL and testbench

- Parametrised successor to the fixed 8-input endstop debounce and mux path.
- N endstop inputs are debounced with a runtime-programmable filter length.
- Each of M motors is mapped to one endstop and an abort direction, using packed config words written by the buffer executor.
- Issues abort requests to the acceleration/profile generators, with a post-trigger timeout window, lockout and unlock strobe.

---
 rtl/endstop_guard.sv | 191 +++++++++++++++++++
 tb/tb_endstop_guard.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/endstop_guard.sv
// endstop_guard: debounced endstop inputs mapped onto motor channels.
// Raises abort requests with a post-trigger window, lockout and unlock.
module endstop_guard #(
  parameter int N_ENDSTOPS = 8,
  parameter int N_MOTORS   = 4,
  parameter int DEB_W      = 8,
  parameter int TO_W       = 32,
  localparam int SEL_W     = $clog2(N_ENDSTOPS),
  localparam int CFG_W     = SEL_W + 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_ENDSTOPS-1:0]     es_raw,
  input  logic [DEB_W-1:0]          deb_len,
  input  logic [N_MOTORS*CFG_W-1:0] motor_cfg,
  input  logic [N_MOTORS-1:0]       motor_dir,
  input  logic [N_MOTORS-1:0]       motor_active,
  input  logic [TO_W-1:0]           es_timeout,
  input  logic                      unlock_stb,
  output logic [N_ENDSTOPS-1:0]     es_state,
  output logic [N_MOTORS-1:0]       abort_req,
  output logic [N_MOTORS-1:0]       abort_mask,
  output logic                      locked,
  output logic                      timed_out
);

  localparam int SEL_N = 1 << SEL_W;

  typedef enum logic [1:0] {
    S_LOCKED,
    S_ARMED,
    S_TRIG
  } state_t;

  logic [N_ENDSTOPS-1:0] sync1;
  logic [N_ENDSTOPS-1:0] sync2;
  logic [N_ENDSTOPS-1:0] es_q;
  logic [DEB_W-1:0]      deb_cnt [N_ENDSTOPS];
  logic [DEB_W-1:0]      deb_lim;
  logic [DEB_W-1:0]      deb_top;
  logic [SEL_N-1:0]      es_ext;
  logic [N_MOTORS-1:0]   hit;
  logic [N_MOTORS-1:0]   new_hit;

  state_t                state_q;
  state_t                state_d;
  logic [N_MOTORS-1:0]   mask_q;
  logic [N_MOTORS-1:0]   mask_d;
  logic [N_MOTORS-1:0]   req_q;
  logic [N_MOTORS-1:0]   req_d;
  logic [TO_W-1:0]       to_q;
  logic [TO_W-1:0]       to_d;
  logic                  tmo_q;
  logic                  tmo_d;

  // Zero length filters behave like a one-cycle filter.
  assign deb_lim = (deb_len == '0) ? DEB_W'(1) : deb_len;
  assign deb_top = deb_lim - DEB_W'(1);

  // Two-flop synchroniser on every raw endstop level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= es_raw;
      sync2 <= sync1;
    end
  end

  // Per-input debounce: flip only after deb_len cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      es_q <= '0;
      for (int i = 0; i < N_ENDSTOPS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ENDSTOPS; i++) begin
        if (sync2[i] == es_q[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] >= deb_top) begin
          es_q[i]    <= ~es_q[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Pad the debounced vector so every select code indexes in range.
  always_comb begin
    es_ext = '0;
    es_ext[N_ENDSTOPS-1:0] = es_q;
  end

  for (genvar m = 0; m < N_MOTORS; m++) begin : g_hit
    logic [CFG_W-1:0] cfg;
    logic [SEL_W-1:0] sel;
    logic             abort_dir;
    logic             en;
    logic             sel_ok;

    assign cfg       = motor_cfg[m*CFG_W +: CFG_W];
    assign sel       = cfg[SEL_W-1:0];
    assign abort_dir = cfg[SEL_W];
    assign en        = cfg[SEL_W+1];
    assign sel_ok    = int'(sel) < N_ENDSTOPS;
    assign hit[m]    = en & sel_ok & motor_active[m]
                     & es_ext[sel]
                     & (motor_dir[m] == abort_dir);
  end

  assign new_hit = hit & ~mask_q;

  // Guard state and its sticky/pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOCKED;
      mask_q  <= '0;
      req_q   <= '0;
      to_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      req_q   <= req_d;
      to_q    <= to_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state: unlock always wins over a hit in the same cycle.
  // The window counts es_timeout cycles of TRIG, at least one.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    req_d   = '0;
    to_d    = to_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_LOCKED: begin
        if (unlock_stb) begin
          state_d = S_ARMED;
          mask_d  = '0;
          tmo_d   = 1'b0;
        end
      end
      S_ARMED: begin
        if (unlock_stb) begin
          mask_d = '0;
          tmo_d  = 1'b0;
        end else if (|hit) begin
          state_d = S_TRIG;
          mask_d  = mask_q | hit;
          req_d   = hit;
          to_d    = es_timeout;
        end
      end
      S_TRIG: begin
        if (unlock_stb) begin
          state_d = S_ARMED;
          mask_d  = '0;
          tmo_d   = 1'b0;
          to_d    = '0;
        end else begin
          mask_d = mask_q | new_hit;
          req_d  = new_hit;
          if (to_q <= TO_W'(1)) begin
            state_d = S_LOCKED;
            tmo_d   = 1'b1;
            to_d    = '0;
          end else begin
            to_d = to_q - TO_W'(1);
          end
        end
      end
      default: begin
        state_d = S_LOCKED;
      end
    endcase
  end

  assign es_state   = es_q;
  assign abort_req  = req_q;
  assign abort_mask = mask_q;
  assign locked     = (state_q == S_LOCKED);
  assign timed_out  = tmo_q;

endmodule

// File: tb/tb_endstop_guard.sv
// tb_endstop_guard: directed stimulus against a cycle model of the guard.
// Six endstops so that select codes 6 and 7 are out of range.
module tb_endstop_guard;

  localparam int NE = 6;
  localparam int NM = 4;
  localparam int DW = 8;
  localparam int TW = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NE-1:0] es_raw;
  logic [DW-1:0] deb_len;
  logic [NM*CW-1:0] motor_cfg;
  logic [NM-1:0] motor_dir;
  logic [NM-1:0] motor_active;
  logic [TW-1:0] es_timeout;
  logic          unlock_stb;
  logic [NE-1:0] es_state;
  logic [NM-1:0] abort_req;
  logic [NM-1:0] abort_mask;
  logic          locked;
  logic          timed_out;

  int checks = 0;
  int failures = 0;

  endstop_guard #(
    .N_ENDSTOPS(NE),
    .N_MOTORS(NM),
    .DEB_W(DW),
    .TO_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .es_raw(es_raw),
    .deb_len(deb_len),
    .motor_cfg(motor_cfg),
    .motor_dir(motor_dir),
    .motor_active(motor_active),
    .es_timeout(es_timeout),
    .unlock_stb(unlock_stb),
    .es_state(es_state),
    .abort_req(abort_req),
    .abort_mask(abort_mask),
    .locked(locked),
    .timed_out(timed_out)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model state
  bit            mv = 1'b0;
  logic [NE-1:0] m_st;
  int            m_run [NE];
  logic [NE-1:0] hist [$];
  int            m_mode;
  longint        m_left;
  logic [NM-1:0] m_mask;
  logic [NM-1:0] m_req;
  bit            m_tmo;
  logic [NM-1:0] m_h;
  logic [NE-1:0] m_d;
  int            m_lim;

  function automatic logic [NM-1:0] model_hit();
    logic [NM-1:0] r;
    int w, sel, dir, en;
    r = '0;
    for (int m = 0; m < NM; m++) begin
      w   = int'(motor_cfg[m*CW +: CW]);
      sel = w % 8;
      dir = (w / 8) % 2;
      en  = w / 16;
      if (en == 1 && motor_active[m] && sel < NE &&
          m_st[sel] && int'(motor_dir[m]) == dir)
        r[m] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mv = 1'b1;
      m_st = '0;
      for (int i = 0; i < NE; i++) m_run[i] = 0;
      hist.delete();
      m_mode = 0;
      m_left = 0;
      m_mask = '0;
      m_req = '0;
      m_tmo = 1'b0;
    end else begin
      m_h = model_hit();
      m_req = '0;
      case (m_mode)
        0: if (unlock_stb) begin
          m_mode = 1; m_mask = '0; m_tmo = 1'b0;
        end
        1: if (unlock_stb) begin
          m_mask = '0; m_tmo = 1'b0;
        end else if (m_h != '0) begin
          m_mode = 2;
          m_mask = m_h;
          m_req = m_h;
          m_left = (es_timeout == 0) ? 1 : longint'(es_timeout);
        end
        default: if (unlock_stb) begin
          m_mode = 1; m_mask = '0; m_tmo = 1'b0;
        end else begin
          m_req = m_h & ~m_mask;
          m_mask = m_mask | m_h;
          m_left--;
          if (m_left == 0) begin
            m_mode = 0; m_tmo = 1'b1;
          end
        end
      endcase
      m_d = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      hist.push_back(es_raw);
      if (hist.size() > 3) void'(hist.pop_front());
      m_lim = (deb_len == 0) ? 1 : int'(deb_len);
      for (int i = 0; i < NE; i++) begin
        if (m_d[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] >= m_lim) begin
            m_st[i] = ~m_st[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("cmp_es_state", 32'(es_state), 32'(m_st));
      chk("cmp_abort_req", 32'(abort_req), 32'(m_req));
      chk("cmp_abort_mask", 32'(abort_mask), 32'(m_mask));
      chk("cmp_locked", 32'(locked), 32'(m_mode == 0));
      chk("cmp_timed_out", 32'(timed_out), 32'(m_tmo));
    end
  end

  int lat;
  int seg [10] = '{3, 4, 5, 2, 7, 20, 100, 100, 200, 300};

  initial begin
    rst = 1'b1;
    es_raw = '0;
    deb_len = 8'd10;
    motor_cfg = '0;
    motor_dir = '0;
    motor_active = '0;
    es_timeout = 32'd500;
    unlock_stb = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("reset_state", 32'({es_state, abort_req, abort_mask,
                            locked, timed_out}), 32'h2);

    es_raw[3] = 1'b1;
    tick(9);
    es_raw[3] = 1'b0;
    tick(15);
    chk("glitch_9", 32'(es_state[3]), 32'h0);

    es_raw[3] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (es_state[3]) begin
        lat = k;
        break;
      end
    end
    chk("latency_12", 32'(lat), 32'd12);
    es_raw[3] = 1'b0;
    tick(20);
    chk("release_3", 32'(es_state[3]), 32'h0);

    deb_len = 8'd8;
    motor_cfg[4:0] = 5'h1A;
    motor_dir[0] = 1'b1;
    motor_active[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      es_raw[2] = (i % 2 == 0);
      tick(seg[i]);
      if (i >= 5)
        chk("bounce_seg", 32'(es_state[2]), 32'(i % 2 == 0));
    end
    chk("locked_no_abort", 32'({locked, abort_mask}), 32'h10);

    motor_active = '0;
    motor_cfg = {5'h1C, 5'h1C, 5'h13, 5'h00};
    motor_dir = 4'b1110;
    es_raw[3] = 1'b1;
    es_raw[4] = 1'b1;
    tick(20);
    unlock_stb = 1'b1;
    tick(1);
    unlock_stb = 1'b0;
    motor_active[1] = 1'b1;
    tick(20);
    chk("opposite_dir", 32'({locked, abort_mask}), 32'h0);

    motor_dir[1] = 1'b0;
    tick(1);
    chk("abort_req_m1", 32'(abort_req), 32'h2);
    chk("abort_mask_m1", 32'(abort_mask), 32'h2);
    tick(1);
    chk("abort_req_once", 32'(abort_req), 32'h0);
    tick(298);
    motor_active[2] = 1'b1;
    tick(1);
    chk("abort_req_m2", 32'(abort_req), 32'h4);
    chk("abort_mask_m12", 32'(abort_mask), 32'h6);
    tick(199);
    chk("window_open", 32'(locked), 32'h0);
    tick(1);
    chk("window_closed", 32'({locked, timed_out}), 32'h3);
    tick(99);
    motor_active[3] = 1'b1;
    tick(2);
    chk("locked_ignores", 32'({abort_req, abort_mask}), 32'h06);

    motor_active = '0;
    es_timeout = '0;
    unlock_stb = 1'b1;
    tick(1);
    unlock_stb = 1'b0;
    chk("unlock_clears", 32'({locked, timed_out, abort_mask}), 32'h0);
    motor_active[1] = 1'b1;
    tick(1);
    chk("to0_pulse", 32'({abort_req, locked}), 32'h04);
    tick(1);
    chk("to0_locked", 32'({locked, timed_out}), 32'h3);

    motor_active = '0;
    unlock_stb = 1'b1;
    tick(1);
    unlock_stb = 1'b0;
    es_raw = 6'h3F;
    motor_dir[0] = 1'b0;
    motor_cfg[4:0] = 5'h17;
    motor_active[0] = 1'b1;
    tick(15);
    motor_cfg[4:0] = 5'h16;
    tick(15);
    chk("sel_oob", 32'({locked, abort_mask}), 32'h0);
    motor_active[0] = 1'b0;
    motor_cfg[4:0] = 5'h00;
    es_raw = 6'h18;

    es_timeout = 32'd1000;
    motor_active[1] = 1'b1;
    tick(1);
    chk("trig_pulse", 32'(abort_req), 32'h2);
    unlock_stb = 1'b1;
    motor_active[2] = 1'b1;
    tick(1);
    unlock_stb = 1'b0;
    chk("unlock_wins", 32'({abort_req, abort_mask, locked}), 32'h0);
    tick(1);
    chk("repulse", 32'({abort_req, abort_mask}), 32'h66);

    motor_active = '0;
    unlock_stb = 1'b1;
    tick(1);
    motor_active[1] = 1'b1;
    tick(1);
    unlock_stb = 1'b0;
    chk("armed_unlock_wins", 32'({abort_req, locked}), 32'h0);
    tick(1);
    chk("armed_next_pulse", 32'(abort_req), 32'h2);

    motor_active[2] = 1'b1;
    tick(800);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("reset_mid_trig", 32'({es_state, abort_req, abort_mask,
                               locked, timed_out}), 32'h2);
    tick(50);
    chk("no_pulse_after_rst", 32'({abort_req, abort_mask, locked}),
        32'h1);
    unlock_stb = 1'b1;
    tick(1);
    unlock_stb = 1'b0;
    tick(1);
    chk("rearm_after_rst", 32'(abort_req), 32'h6);
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
